// File: rtl/sparse_packer.sv
// Zero-skipping tile writer: drops zero elements, tags nonzeros with their tile index and
// writes them alternately to lane 0 / lane 1, padding lane 1 so both lanes end equal.
module sparse_packer #(
    parameter int unsigned DW = 8,
    parameter int unsigned IW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         tile_len,
    input  logic               in_valid,
    input  logic [DW-1:0]      in_data,
    output logic               in_ready,
    output logic               buf_clear,
    output logic [DW+IW-1:0]   data_0,
    output logic [DW+IW-1:0]   data_1,
    output logic               write_enable_0,
    output logic               write_enable_1,
    output logic [7:0]         nz_count,
    output logic               busy,
    output logic               done
);

    localparam int unsigned EW = DW + IW;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SCAN  = 3'd2,
        S_PAD   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_nz;
    logic            r_toggle;

    logic            r_in_ready;
    logic            r_buf_clear;
    logic [EW-1:0]   r_data_0;
    logic [EW-1:0]   r_data_1;
    logic            r_we_0;
    logic            r_we_1;
    logic [CW-1:0]   r_nz_count;
    logic            r_busy;
    logic            r_done;

    logic            w_fire;
    logic            w_nonzero;
    logic            w_wr_nz;
    logic            w_last;
    logic [CW-1:0]   w_nz_next;
    logic [EW-1:0]   w_entry;

    logic            w_in_ready;
    logic            w_buf_clear;
    logic [EW-1:0]   w_data_0;
    logic [EW-1:0]   w_data_1;
    logic            w_we_0;
    logic            w_we_1;
    logic [CW-1:0]   w_nz_count;
    logic            w_busy;
    logic            w_done;

    // Element handshake and the nonzero count including this cycle's element
    always_comb begin
        w_fire    = (r_state == S_SCAN) && in_valid;
        w_nonzero = (in_data != '0);
        w_wr_nz   = w_fire && w_nonzero;
        w_last    = (r_k == (r_len - CW'(1)));
        w_nz_next = w_wr_nz ? (r_nz + CW'(1)) : r_nz;
        w_entry   = {IW'(r_k), in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next_state = (r_len != '0) ? S_SCAN : S_DONE;
            end
            S_SCAN: begin
                if (w_fire && w_last) begin
                    w_next_state = w_nz_next[0] ? S_PAD : S_DONE;
                end
            end
            S_PAD:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so their registered copies line up with it
    always_comb begin
        w_in_ready  = (w_next_state == S_SCAN);
        w_buf_clear = (w_next_state == S_CLEAR);
        w_busy      = (w_next_state != S_IDLE);
        w_done      = (w_next_state == S_DONE);
        w_we_0      = 1'b0;
        w_we_1      = 1'b0;
        w_data_0    = r_data_0;
        w_data_1    = r_data_1;
        w_nz_count  = r_nz_count;
        if (w_wr_nz && !r_toggle) begin
            w_we_0   = 1'b1;
            w_data_0 = w_entry;
        end
        if (w_wr_nz && r_toggle) begin
            w_we_1   = 1'b1;
            w_data_1 = w_entry;
        end
        if (r_state == S_PAD) begin
            w_we_1   = 1'b1;
            w_data_1 = '0;
        end
        if (w_next_state == S_DONE) begin
            w_nz_count = w_nz_next;
        end
    end

    // Tile bookkeeping: length, element index, nonzero count, lane toggle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len    <= '0;
            r_k      <= '0;
            r_nz     <= '0;
            r_toggle <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_len    <= tile_len;
            r_k      <= '0;
            r_nz     <= '0;
            r_toggle <= 1'b0;
        end else if (w_fire) begin
            r_k  <= r_k + CW'(1);
            r_nz <= w_nz_next;
            if (w_nonzero) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_buf_clear <= 1'b0;
            r_data_0    <= '0;
            r_data_1    <= '0;
            r_we_0      <= 1'b0;
            r_we_1      <= 1'b0;
            r_nz_count  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready;
            r_buf_clear <= w_buf_clear;
            r_data_0    <= w_data_0;
            r_data_1    <= w_data_1;
            r_we_0      <= w_we_0;
            r_we_1      <= w_we_1;
            r_nz_count  <= w_nz_count;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign in_ready       = r_in_ready;
    assign buf_clear      = r_buf_clear;
    assign data_0         = r_data_0;
    assign data_1         = r_data_1;
    assign write_enable_0 = r_we_0;
    assign write_enable_1 = r_we_1;
    assign nz_count       = r_nz_count;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_sparse_packer.sv
// Bench for sparse_packer: random and directed tiles checked against a per-tile model of
// which entries must land on which lane and in which cycle.
module tb_sparse_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        tile_len;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              buf_clear;
    logic [15:0]       data_0;
    logic [15:0]       data_1;
    logic              write_enable_0;
    logic              write_enable_1;
    logic [7:0]        nz_count;
    logic              busy;
    logic              done;

    sparse_packer #(.DW(DW), .IW(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .tile_len       (tile_len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .buf_clear      (buf_clear),
        .data_0         (data_0),
        .data_1         (data_1),
        .write_enable_0 (write_enable_0),
        .write_enable_1 (write_enable_1),
        .nz_count       (nz_count),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } wr_t;

    wr_t mon_l0[$];
    wr_t mon_l1[$];
    int  mon_done     = 0;
    int  mon_done_cyc = 0;
    int  mon_both     = 0;
    int  mon_clear    = 0;
    int  mon_rdy      = 0;

    // Observe outputs mid-cycle; counters only ever grow, tiles use deltas
    always @(negedge clk) begin
        if (write_enable_0) mon_l0.push_back('{cyc, data_0});
        if (write_enable_1) mon_l1.push_back('{cyc, data_1});
        if (write_enable_0 && write_enable_1) mon_both <= mon_both + 1;
        if (done) begin
            mon_done     <= mon_done + 1;
            mon_done_cyc <= cyc;
        end
        if (buf_clear) mon_clear <= mon_clear + 1;
        if (in_ready)  mon_rdy   <= mon_rdy + 1;
    end

    int               n_chk   = 0;
    int               n_fail  = 0;
    int               prev_nz = 0;
    logic signed [7:0] tile_data [256];
    int               acc_cyc [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input int len, input int zero_pct);
        int v;
        for (int i = 0; i < len; i++) begin
            if (int'($urandom_range(99)) < zero_pct) begin
                tile_data[i] = 8'sd0;
            end else begin
                v = int'($urandom_range(255));
                if (v == 0) v = 1;
                tile_data[i] = 8'(v);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"},  32'(in_ready), 0);
        check({tag, " buf_clear"}, 32'(buf_clear), 0);
        check({tag, " data_0"},    32'(data_0), 0);
        check({tag, " data_1"},    32'(data_1), 0);
        check({tag, " we_0"},      32'(write_enable_0), 0);
        check({tag, " we_1"},      32'(write_enable_1), 0);
        check({tag, " nz_count"},  32'(nz_count), 0);
        check({tag, " busy"},      32'(busy), 0);
        check({tag, " done"},      32'(done), 0);
    endtask

    // One tile from start to IDLE, then compare against the model built from tile_data
    task automatic run_tile(input int len, input int gap_pct, input bit start_mid, input bit start_done);
        int  b0 = mon_l0.size();
        int  b1 = mon_l1.size();
        int  d0 = mon_done;
        int  c0 = mon_clear;
        int  r0 = mon_rdy;
        int  bb = mon_both;
        int  t0;
        int  last = 0;
        int  idx = 0;
        int  budget;
        int  nz = 0;
        int  exp_done;
        bit  mid_sent = 1'b0;
        wr_t e0[$];
        wr_t e1[$];

        start    = 1'b1;
        tile_len = 8'(len);
        t0       = cyc;
        tick();
        start = 1'b0;
        check("busy after start", 32'(busy), 1);
        check("buf_clear after start", 32'(buf_clear), 1);
        check("nz_count held", 32'(nz_count), 32'(prev_nz));

        budget = 4000;
        while (idx < len && budget > 0) begin
            in_valid = (int'($urandom_range(99)) >= gap_pct);
            in_data  = tile_data[idx];
            start    = 1'b0;
            if (start_mid && !mid_sent && idx == len / 2) begin
                start    = 1'b1;
                tile_len = 8'd3;
                mid_sent = 1'b1;
            end
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc;
                last         = cyc;
                idx++;
            end
            tick();
            budget--;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("scan handshakes", 32'(idx), 32'(len));

        budget = 10;
        while (mon_done == d0 && budget > 0) begin
            tick();
            budget--;
        end
        if (start_done) start = 1'b1;
        tick();
        start = 1'b0;
        check("busy back to idle", 32'(busy), 0);
        check("in_ready in idle", 32'(in_ready), 0);
        tick();
        check("stays idle", 32'(busy), 0);

        for (int i = 0; i < len; i++) begin
            if (tile_data[i] != 8'sd0) begin
                if (nz % 2 == 0) e0.push_back('{acc_cyc[i] + 1, {8'(i), tile_data[i]}});
                else             e1.push_back('{acc_cyc[i] + 1, {8'(i), tile_data[i]}});
                nz++;
            end
        end
        if (nz % 2 == 1) e1.push_back('{last + 2, 16'h0000});

        exp_done = (len == 0) ? t0 + 2 : last + ((nz % 2 == 1) ? 2 : 1);
        check("done pulses", 32'(mon_done - d0), 1);
        check("done cycle", 32'(mon_done_cyc), 32'(exp_done));
        check("nz_count", 32'(nz_count), 32'(nz));
        check("buf_clear pulses", 32'(mon_clear - c0), 1);
        check("both lanes same cycle", 32'(mon_both - bb), 0);
        if (len == 0) check("in_ready with len 0", 32'(mon_rdy - r0), 0);
        check("lane0 writes", 32'(mon_l0.size() - b0), 32'(e0.size()));
        check("lane1 writes", 32'(mon_l1.size() - b1), 32'(e1.size()));
        for (int i = 0; i < e0.size(); i++) begin
            if (b0 + i < mon_l0.size()) begin
                check("lane0 entry", 32'(mon_l0[b0 + i].d), 32'(e0[i].d));
                check("lane0 cycle", 32'(mon_l0[b0 + i].cyc), 32'(e0[i].cyc));
            end
        end
        for (int i = 0; i < e1.size(); i++) begin
            if (b1 + i < mon_l1.size()) begin
                check("lane1 entry", 32'(mon_l1[b1 + i].d), 32'(e1[i].d));
                check("lane1 cycle", 32'(mon_l1[b1 + i].cyc), 32'(e1[i].cyc));
            end
        end
        prev_nz = nz;
    endtask

    initial begin
        int len;
        reset    = 1'b1;
        start    = 1'b0;
        tile_len = 8'd0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");

        // Mixed tile: odd count, lane 1 padded
        tile_data[0] = 8'sd3;
        tile_data[1] = 8'sd0;
        tile_data[2] = -8'sd2;
        tile_data[3] = 8'sd5;
        run_tile(4, 0, 1'b0, 1'b0);

        fill(8, 100);
        run_tile(8, 0, 1'b0, 1'b0);

        run_tile(0, 0, 1'b0, 1'b0);

        fill(6, 0);
        run_tile(6, 50, 1'b0, 1'b0);

        fill(255, 0);
        run_tile(255, 20, 1'b1, 1'b1);

        tile_data[0] = -8'sd128;
        run_tile(1, 0, 1'b0, 1'b0);

        // Abandon a tile mid-scan with reset, then run a fresh one
        fill(10, 0);
        start    = 1'b1;
        tile_len = 8'd10;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = tile_data[i];
            tick();
        end
        reset = 1'b1;
        #1;
        check_all_zero("mid-scan reset");
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        prev_nz = 0;
        fill(10, 30);
        run_tile(10, 30, 1'b0, 1'b0);

        repeat (6) begin
            len = int'($urandom_range(24, 1));
            fill(len, 35);
            run_tile(len, 25, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
